// File: rtl/sprite_palette_ram.sv
// ---------------------------------------------------------------------------
// sprite_palette_ram
//
// Multi-bank sprite palette. A per-pixel colour index is looked up in the
// palette selected by active_pal and returned as RGB two cycles later. The
// active palette only changes on frame_start, so a frame is never drawn with
// a mix of palettes. An optional fade unit darkens every channel by a
// frame-timed amount for screen transitions.
//
// Build option:
//   PALETTE_FADE_EN  defined   -> fade FSM, frame counter and subtractor present
//                    undefined -> fade_level/fade_busy tied to 0, fade_cmd ignored
//
// Ports:
//   Clk, Reset          system clock (rising edge), async active-high reset
//   frame_start         one-cycle pulse at end of vblank
//   pal_sel_next        palette that becomes active at the next frame_start
//   rd_valid_in/index   pixel index stream in
//   rd_valid_out        red/green/blue/transparent valid (2-cycle latency)
//   red/green/blue      pixel colour, 0 when rd_valid_out is low
//   transparent         pixel index was 0
//   wr_en/pal/index/rgb palette write port, {r,g,b} data
//   fade_cmd            00 none, 01 fade out, 10 fade in, 11 ignored
//   fade_level          current darkening amount
//   fade_busy           fade in progress
//
// Fade FSM states:
//   state      | meaning
//   IDLE       | no darkening, waiting for fade-out command
//   FADING_OUT | level rises by 1 every FADE_FRAMES frames
//   DARK       | level at maximum, waiting for fade-in command
//   FADING_IN  | level falls by 1 every FADE_FRAMES frames
// ---------------------------------------------------------------------------
module sprite_palette_ram #(
  parameter int INDEX_W     = 4,
  parameter int CHAN_W      = 4,
  parameter int NUM_PAL     = 4,
  parameter int FADE_FRAMES = 4,
  localparam int PAL_W      = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [PAL_W-1:0]      pal_sel_next,
  input  logic                  rd_valid_in,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid_out,
  output logic [CHAN_W-1:0]     red,
  output logic [CHAN_W-1:0]     green,
  output logic [CHAN_W-1:0]     blue,
  output logic                  transparent,
  input  logic                  wr_en,
  input  logic [PAL_W-1:0]      wr_pal,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [3*CHAN_W-1:0]   wr_rgb,
  input  logic [1:0]            fade_cmd,
  output logic [CHAN_W-1:0]     fade_level,
  output logic                  fade_busy
);

  localparam int ADDR_W = PAL_W + INDEX_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RGB_W  = 3 * CHAN_W;

  // -------------------------------------------------------------------------
  // Palette storage (not reset; the boot loader fills every entry)
  // -------------------------------------------------------------------------
  logic [RGB_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[{wr_pal, wr_index}] <= wr_rgb;
    end
  end

  // -------------------------------------------------------------------------
  // Active palette, switched only at frame boundaries
  // -------------------------------------------------------------------------
  logic [PAL_W-1:0] active_pal_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active_pal_q <= '0;
    end else if (frame_start) begin
      active_pal_q <= pal_sel_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: RAM read. The array is sampled before the same-edge write lands,
  // so a colliding read returns the old word, and a read coinciding with
  // frame_start still uses the old active_pal.
  // -------------------------------------------------------------------------
  logic             s1_valid_q;
  logic             s1_zero_q;
  logic [RGB_W-1:0] s1_rgb_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_rgb_q   <= '0;
    end else begin
      s1_valid_q <= rd_valid_in;
      s1_zero_q  <= (rd_index == '0);
      s1_rgb_q   <= mem_q[{active_pal_q, rd_index}];
    end
  end

  // -------------------------------------------------------------------------
  // Fade unit
  // -------------------------------------------------------------------------
  logic [CHAN_W-1:0] fade_lvl;

`ifdef PALETTE_FADE_EN
  localparam int                CNT_W      = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(FADE_FRAMES - 1);
  localparam logic [CHAN_W-1:0] LEVEL_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FADING_OUT = 2'd1,
    DARK       = 2'd2,
    FADING_IN  = 2'd3
  } fade_state_e;

  fade_state_e       state_q, state_d;
  logic [CHAN_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame timer is a down-counter: loaded with FADE_FRAMES-1 when a fade is
  // accepted, a step happens on the frame_start that finds it at zero. A
  // frame_start arriving with the accepting command is not counted because
  // IDLE/DARK never look at the counter.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fade_cmd == 2'b01) begin
          state_d = FADING_OUT;
          cnt_d   = CNT_RELOAD;
        end
      end
      FADING_OUT: begin
        if (frame_start) begin
          if (cnt_q == '0) begin
            level_d = level_q + CHAN_W'(1);
            cnt_d   = CNT_RELOAD;
            if (level_d == LEVEL_MAX) begin
              state_d = DARK;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DARK: begin
        if (fade_cmd == 2'b10) begin
          state_d = FADING_IN;
          cnt_d   = CNT_RELOAD;
        end
      end
      FADING_IN: begin
        if (frame_start) begin
          if (cnt_q == '0) begin
            level_d = level_q - CHAN_W'(1);
            cnt_d   = CNT_RELOAD;
            if (level_d == '0) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fade_lvl   = level_q;
  assign fade_level = level_q;
  assign fade_busy  = (state_q == FADING_OUT) || (state_q == FADING_IN);
`else
  localparam int unused_fade_frames = FADE_FRAMES;
  logic unused_fade_cmd;

  assign unused_fade_cmd = ^fade_cmd;
  assign fade_lvl        = '0;
  assign fade_level      = '0;
  assign fade_busy       = 1'b0;
`endif

  // Channel minus level, computed one bit wider so an underflow clamps to 0
  // instead of wrapping.
  function automatic logic [CHAN_W-1:0] sub_sat(input logic [CHAN_W-1:0] chan,
                                                input logic [CHAN_W-1:0] lvl);
    logic [CHAN_W:0] diff;
    diff = {1'b0, chan} - {1'b0, lvl};
    return diff[CHAN_W] ? '0 : diff[CHAN_W-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Stage 2: fade and output register. fade_lvl is the level after any
  // update on the edge that loaded S1, so in-flight pixels see the new level.
  // -------------------------------------------------------------------------
  logic              valid_q, valid_d;
  logic              transp_q, transp_d;
  logic [CHAN_W-1:0] red_q, red_d;
  logic [CHAN_W-1:0] green_q, green_d;
  logic [CHAN_W-1:0] blue_q, blue_d;

  always_comb begin
    valid_d  = s1_valid_q;
    transp_d = 1'b0;
    red_d    = '0;
    green_d  = '0;
    blue_d   = '0;
    if (s1_valid_q) begin
      transp_d = s1_zero_q;
`ifdef PALETTE_FADE_EN
      red_d    = sub_sat(s1_rgb_q[3*CHAN_W-1:2*CHAN_W], fade_lvl);
      green_d  = sub_sat(s1_rgb_q[2*CHAN_W-1:CHAN_W],   fade_lvl);
      blue_d   = sub_sat(s1_rgb_q[CHAN_W-1:0],          fade_lvl);
`else
      red_d    = s1_rgb_q[3*CHAN_W-1:2*CHAN_W];
      green_d  = s1_rgb_q[2*CHAN_W-1:CHAN_W];
      blue_d   = s1_rgb_q[CHAN_W-1:0];
`endif
    end
  end

`ifndef PALETTE_FADE_EN
  logic unused_sub;
  assign unused_sub = ^sub_sat(fade_lvl, fade_lvl);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      transp_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      transp_q <= transp_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign rd_valid_out = valid_q;
  assign transparent  = transp_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;

endmodule

// File: tb/tb_sprite_palette_ram.sv
module tb_sprite_palette_ram;

  localparam int INDEX_W     = 4;
  localparam int CHAN_W      = 4;
  localparam int NUM_PAL     = 4;
  localparam int FADE_FRAMES = 2;
  localparam int PAL_W       = 2;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                frame_start;
  logic [PAL_W-1:0]    pal_sel_next;
  logic                rd_valid_in;
  logic [INDEX_W-1:0]  rd_index;
  logic                rd_valid_out;
  logic [CHAN_W-1:0]   red, green, blue;
  logic                transparent;
  logic                wr_en;
  logic [PAL_W-1:0]    wr_pal;
  logic [INDEX_W-1:0]  wr_index;
  logic [3*CHAN_W-1:0] wr_rgb;
  logic [1:0]          fade_cmd;
  logic [CHAN_W-1:0]   fade_level;
  logic                fade_busy;

  int n_vec = 0;
  int n_err = 0;

  sprite_palette_ram #(
    .INDEX_W(INDEX_W), .CHAN_W(CHAN_W), .NUM_PAL(NUM_PAL), .FADE_FRAMES(FADE_FRAMES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pal_sel_next(pal_sel_next),
    .rd_valid_in(rd_valid_in), .rd_index(rd_index), .rd_valid_out(rd_valid_out),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .fade_cmd(fade_cmd), .fade_level(fade_level), .fade_busy(fade_busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [PAL_W-1:0] p, input logic [INDEX_W-1:0] i,
                    input logic [3*CHAN_W-1:0] rgb);
    wr_pal = p; wr_index = i; wr_rgb = rgb; wr_en = 1'b1;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic frame_pulse;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    tick;
  endtask

  // one pixel in, result visible after the second edge
  task automatic rd_check(input string tag, input logic [INDEX_W-1:0] idx,
                          input logic [11:0] exp_rgb, input logic exp_tr);
    rd_valid_in = 1'b1; rd_index = idx;
    tick;
    rd_valid_in = 1'b0;
    tick;
    chk(tag, {rd_valid_out, transparent, red, green, blue}, {1'b1, exp_tr, exp_rgb});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pal_sel_next = '0;
    rd_valid_in = 1'b0; rd_index = '0;
    wr_en = 1'b0; wr_pal = '0; wr_index = '0; wr_rgb = '0; fade_cmd = 2'b00;
    tick; tick;
    chk("rst_pix",  {rd_valid_out, transparent, red, green, blue}, 32'h0);
    chk("rst_fade", {fade_busy, fade_level}, 32'h0);
    Reset = 1'b0;
    tick;

    wr(2'd0, 4'd5, 12'h111);
    wr(2'd1, 4'd5, 12'h777);
    wr(2'd2, 4'd5, 12'hA3C);
    wr(2'd2, 4'd0, 12'h456);
    wr(2'd2, 4'd3, 12'h123);

    rd_check("pal0_e5", 4'd5, 12'h111, 1'b0);
    pal_sel_next = 2'd2;
    frame_pulse;
    rd_check("pal2_e5", 4'd5, 12'hA3C, 1'b0);
    rd_check("pal2_e0", 4'd0, 12'h456, 1'b1);
    tick;
    chk("blank", {rd_valid_out, transparent, red, green, blue}, 32'h0);

    // latency exactly two cycles
    rd_valid_in = 1'b1; rd_index = 4'd5;
    tick;
    rd_valid_in = 1'b0;
    chk("lat1", {31'b0, rd_valid_out}, 32'h0);
    tick;
    chk("lat2", {rd_valid_out, red, green, blue}, {1'b1, 12'hA3C});
    tick;

    // frame-aligned switch while streaming index 5
    pal_sel_next = 2'd1;
    rd_valid_in = 1'b1; rd_index = 4'd5;
    tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("sw_before",  {rd_valid_out, red, green, blue}, {1'b1, 12'hA3C});
    tick;
    chk("sw_same_fs", {rd_valid_out, red, green, blue}, {1'b1, 12'hA3C});
    tick;
    chk("sw_after",   {rd_valid_out, red, green, blue}, {1'b1, 12'h777});
    rd_valid_in = 1'b0;
    tick; tick;
    pal_sel_next = 2'd2;
    frame_pulse;

    // read/write collision on palette 2 entry 3
    wr_pal = 2'd2; wr_index = 4'd3; wr_rgb = 12'hFFF; wr_en = 1'b1;
    rd_valid_in = 1'b1; rd_index = 4'd3;
    tick;
    wr_en = 1'b0;
    tick;
    chk("coll_old", {rd_valid_out, red, green, blue}, {1'b1, 12'h123});
    rd_valid_in = 1'b0;
    tick;
    chk("coll_new", {rd_valid_out, red, green, blue}, {1'b1, 12'hFFF});
    tick;

`ifdef PALETTE_FADE_EN
    fade_cmd = 2'b01;
    tick;
    fade_cmd = 2'b00;
    chk("fo_start", {fade_busy, fade_level}, {27'b0, 1'b1, 4'd0});
    frame_pulse;
    chk("fo_1p", {28'b0, fade_level}, 32'd0);
    frame_pulse;
    chk("fo_2p", {28'b0, fade_level}, 32'd1);
    rd_check("fo_l1_px", 4'd5, 12'h92B, 1'b0);
    fade_cmd = 2'b10;
    tick;
    fade_cmd = 2'b00;
    chk("fo_rev_ign", {fade_busy, fade_level}, {27'b0, 1'b1, 4'd1});
    frame_pulse;
    rd_valid_in = 1'b1; rd_index = 4'd5; frame_start = 1'b1;
    tick;
    rd_valid_in = 1'b0; frame_start = 1'b0;
    tick;
    chk("s1_newlvl", {rd_valid_out, red, green, blue, fade_level}, {1'b1, 12'h81A, 4'd2});
    repeat (4) frame_pulse;
    chk("fo_lvl4", {28'b0, fade_level}, 32'd4);
    rd_check("fo_l4_px", 4'd5, 12'h608, 1'b0);
    repeat (21) frame_pulse;
    chk("fo_lvl14", {fade_busy, fade_level}, {27'b0, 1'b1, 4'd14});
    frame_pulse;
    chk("dark", {fade_busy, fade_level}, {27'b0, 1'b0, 4'd15});
    rd_check("dark_px", 4'd5, 12'h000, 1'b0);

    // fade-in accepted together with frame_start; that pulse is not counted
    fade_cmd = 2'b10; frame_start = 1'b1;
    tick;
    fade_cmd = 2'b00; frame_start = 1'b0;
    tick;
    chk("fi_start", {fade_busy, fade_level}, {27'b0, 1'b1, 4'd15});
    frame_pulse;
    chk("fi_1p", {28'b0, fade_level}, 32'd15);
    frame_pulse;
    chk("fi_2p", {28'b0, fade_level}, 32'd14);
    repeat (27) frame_pulse;
    chk("fi_29p", {fade_busy, fade_level}, {27'b0, 1'b1, 4'd1});
    frame_pulse;
    chk("fi_30p", {fade_busy, fade_level}, 32'h0);
    rd_check("fi_px", 4'd5, 12'hA3C, 1'b0);

    // reset in the middle of a fade with a pixel in flight
    fade_cmd = 2'b01;
    tick;
    fade_cmd = 2'b00;
    repeat (14) frame_pulse;
    chk("pre_rst_lvl", {28'b0, fade_level}, 32'd7);
    rd_valid_in = 1'b1; rd_index = 4'd5;
    tick; tick;
    chk("pre_rst_px", {rd_valid_out, red, green, blue}, {1'b1, 12'h305});
`else
    fade_cmd = 2'b01;
    tick;
    fade_cmd = 2'b00;
    repeat (4) frame_pulse;
    chk("nf_fade", {fade_busy, fade_level}, 32'h0);
    rd_check("nf_px", 4'd5, 12'hA3C, 1'b0);
    rd_valid_in = 1'b1; rd_index = 4'd5;
    tick; tick;
    chk("pre_rst_px", {rd_valid_out, red, green, blue}, {1'b1, 12'hA3C});
`endif

    #2;
    Reset = 1'b1;
    #1;
    chk("rst_mid", {rd_valid_out, transparent, red, green, blue, fade_busy, fade_level}, 32'h0);
    rd_valid_in = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    tick;
    rd_check("post_rst_p0", 4'd5, 12'h111, 1'b0);
    pal_sel_next = 2'd2;
    frame_pulse;
    rd_check("post_rst_p2", 4'd5, 12'hA3C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
